semaforo_sensor_timer: RTL and testbench

Environment-side companion to the traffic-light FSM: watches the FSM's lamp outputs (GRN, YLW, RED) and produces the two inputs the FSM consumes, CAR and TIMEOUT. It conditions a raw, asynchronous car-sensor line with a synchroniser, a debouncer and a minimum-green gate. It also times the red phase to generate TIMEOUT. It sits between the physical sensor and the FSM, so the FSM never sees raw sensor glitches and needs no internal timer.

---
 rtl/semaforo_sensor_timer.sv | 125 ++++++++++++
 tb/tb_semaforo_sensor_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/semaforo_sensor_timer.sv
// Purpose : conditions the raw car sensor (sync + debounce + minimum-green gate) into CAR,
//           and times the red phase into TIMEOUT, for the traffic-light FSM.
// Latency : car_in -> car_db is 2 + DEBOUNCE edges; CAR/TIMEOUT are registered one edge after their conditions.
// Backpressure: none; free-running observer of the lamp outputs, no handshake.
//
// Ports:
//   clk        system clock, rising edge
//   res        asynchronous active-high reset
//   car_in     raw, asynchronous, bouncing car sensor
//   GRN/YLW/RED lamp outputs of the FSM
//   CAR        conditioned car request (registered)
//   TIMEOUT    red-phase timeout level (registered)
//   lamp_fault sticky illegal-lamp flag (registered)
//
// Optional feature: SEMAFORO_FAULT_EN enables lamp-combination fault detection
// and output forcing; when undefined lamp_fault is tied to 0.
module semaforo_sensor_timer #(
   parameter int RED_CYCLES = 4,
   parameter int MIN_GREEN  = 2,
   parameter int DEBOUNCE   = 3,
   parameter int CNT_W      = 8
) (
   input  logic clk,
   input  logic res,
   input  logic car_in,
   input  logic GRN,
   input  logic YLW,
   input  logic RED,
   output logic CAR,
   output logic TIMEOUT,
   output logic lamp_fault
);

   // Thresholds compared at CNT_W+1 bits so cnt+1 never wraps.
   localparam logic [CNT_W:0]   C_RED_CYCLES = (CNT_W+1)'(RED_CYCLES);
   localparam logic [CNT_W:0]   C_MIN_GREEN  = (CNT_W+1)'(MIN_GREEN);
   localparam logic [CNT_W-1:0] C_DEB_LAST   = (CNT_W)'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] C_ONE        = (CNT_W)'(1);
   localparam logic [CNT_W-1:0] C_MAX        = '1;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_car_db;
   logic [CNT_W-1:0] r_deb_cnt;
   logic [CNT_W-1:0] r_grn_cnt;
   logic [CNT_W-1:0] r_red_cnt;
   logic             r_car;
   logic             r_timeout;

   logic [CNT_W:0]   w_grn_inc;
   logic [CNT_W:0]   w_red_inc;
   logic             w_grn_ok;
   logic             w_red_ok;
   logic             w_force;

   assign w_grn_inc = {1'b0, r_grn_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign w_red_inc = {1'b0, r_red_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign w_grn_ok  = (w_grn_inc >= C_MIN_GREEN);
   assign w_red_ok  = (w_red_inc >= C_RED_CYCLES);

`ifdef SEMAFORO_FAULT_EN
   logic       r_fault;
   logic [1:0] w_lamp_cnt;
   logic       w_fault_nxt;

   assign w_lamp_cnt  = {1'b0, GRN} + {1'b0, YLW} + {1'b0, RED};
   assign w_fault_nxt = r_fault | (w_lamp_cnt != 2'd1);
   // Force on the next-state value so the edge that detects the fault already yields 0 outputs.
   assign w_force     = w_fault_nxt;
   assign lamp_fault  = r_fault;

   always_ff @(posedge clk or posedge res) begin
      if (res) r_fault <= 1'b0;
      else     r_fault <= w_fault_nxt;
   end
`else
   // YLW only matters for fault checking, which is absent in this build.
   logic w_unused_ylw;
   assign w_unused_ylw = YLW;
   assign w_force      = 1'b0;
   assign lamp_fault   = 1'b0;
`endif

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_car_db  <= 1'b0;
         r_deb_cnt <= '0;
         r_grn_cnt <= '0;
         r_red_cnt <= '0;
         r_car     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_sync1 <= car_in;
         r_sync2 <= r_sync1;

         // Debounce: a new level needs DEBOUNCE consecutive differing samples.
         if (r_sync2 != r_car_db) begin
            if (r_deb_cnt == C_DEB_LAST) begin
               r_car_db  <= r_sync2;
               r_deb_cnt <= '0;
            end else begin
               r_deb_cnt <= r_deb_cnt + C_ONE;
            end
         end else begin
            r_deb_cnt <= '0;
         end

         if (!GRN)                   r_grn_cnt <= '0;
         else if (r_grn_cnt != C_MAX) r_grn_cnt <= r_grn_cnt + C_ONE;

         if (!RED)                   r_red_cnt <= '0;
         else if (r_red_cnt != C_MAX) r_red_cnt <= r_red_cnt + C_ONE;

         // Pre-edge car_db and counters decide the outputs.
         r_car     <= GRN & r_car_db & w_grn_ok & ~w_force;
         r_timeout <= RED & w_red_ok & ~w_force;
      end
   end

   assign CAR     = r_car;
   assign TIMEOUT = r_timeout;

endmodule

// File: tb/tb_semaforo_sensor_timer.sv
// Purpose : self-checking bench for semaforo_sensor_timer (default parameters, 10 ns clock).
// Latency : model is updated at each rising edge and compared 1 ns later.
// Backpressure: not applicable.
module tb_semaforo_sensor_timer;
   localparam int RC = 4;
   localparam int MG = 2;
   localparam int DB = 3;
`ifdef SEMAFORO_FAULT_EN
   localparam bit FAULT_ON = 1'b1;
`else
   localparam bit FAULT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic res, car_in, GRN, YLW, RED;
   logic CAR, TIMEOUT, lamp_fault;

   int errors = 0;
   int checks = 0;

   semaforo_sensor_timer #(.RED_CYCLES(RC), .MIN_GREEN(MG), .DEBOUNCE(DB), .CNT_W(8)) dut (
      .clk(clk), .res(res), .car_in(car_in), .GRN(GRN), .YLW(YLW), .RED(RED),
      .CAR(CAR), .TIMEOUT(TIMEOUT), .lamp_fault(lamp_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Works from sample histories and run lengths rather than counters:
   // car_s seen at an edge is the car_in sampled two edges earlier; the
   // debounced level flips when the last DB car_s samples all disagree with it.
   logic m_car_hist[$];
   logic m_cs_hist[$];
   logic m_db, m_car, m_to, m_fault;
   int   m_grn_run, m_red_run;

   always @(posedge clk) begin
      logic cs, db_pre, all_diff;
      int   n;
      if (res) begin
         m_car_hist.delete();
         m_cs_hist.delete();
         m_db = 1'b0; m_car = 1'b0; m_to = 1'b0; m_fault = 1'b0;
         m_grn_run = 0; m_red_run = 0;
      end else begin
         n  = m_car_hist.size();
         cs = (n >= 2) ? m_car_hist[n-2] : 1'b0;
         m_car_hist.push_back(car_in);
         m_cs_hist.push_back(cs);
         db_pre = m_db;
         if (m_cs_hist.size() >= DB) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++)
               if (m_cs_hist[m_cs_hist.size()-1-k] == m_db) all_diff = 1'b0;
            if (all_diff) m_db = ~m_db;
         end
         m_grn_run = GRN ? m_grn_run + 1 : 0;
         m_red_run = RED ? m_red_run + 1 : 0;
         if (FAULT_ON && ((int'(GRN) + int'(YLW) + int'(RED)) != 1)) m_fault = 1'b1;
         m_car = GRN && db_pre && (m_grn_run >= MG) && !m_fault;
         m_to  = RED && (m_red_run >= RC) && !m_fault;
      end
      #1;
      chk("model_CAR", CAR, m_car);
      chk("model_TIMEOUT", TIMEOUT, m_to);
      chk("model_lamp_fault", lamp_fault, m_fault);
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      res = 1'b1; car_in = 1'b1; RED = 1'b1; GRN = 1'b0; YLW = 1'b0;
      tick(3);
      chk("reset_CAR", CAR, 1'b0);
      chk("reset_TIMEOUT", TIMEOUT, 1'b0);
      chk("reset_fault", lamp_fault, 1'b0);
      res = 1'b0;
      tick();
      chk("first_edge_CAR", CAR, 1'b0);
      chk("first_edge_TIMEOUT", TIMEOUT, 1'b0);
      chk("first_edge_fault", lamp_fault, 1'b0);
      // Red timeout: edges 2,3 low, edge 4 high, stays high as a level.
      tick(); chk("red_e2", TIMEOUT, 1'b0);
      tick(); chk("red_e3", TIMEOUT, 1'b0);
      tick(); chk("red_e4", TIMEOUT, 1'b1);
      tick(); chk("red_e5_level", TIMEOUT, 1'b1);

      // Green phase, sensor released so car_db returns to 0.
      RED = 1'b0; GRN = 1'b1; car_in = 1'b0;
      tick(); chk("red_drop", TIMEOUT, 1'b0);
      tick(8);

      // Bounce rejection.
      for (int i = 0; i < 10; i++) begin
         car_in = (i % 2 == 0);
         tick();
         chk("bounce_CAR", CAR, 1'b0);
      end
      car_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("bounce_settle_CAR", CAR, 1'b0);
      end

      // Car request: car_db rises 5 edges after the first edge sampling car_in=1,
      // CAR one edge after that.
      car_in = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("carreq_low", CAR, 1'b0);
      end
      tick(); chk("carreq_rise", CAR, 1'b1);
      tick(); chk("carreq_hold", CAR, 1'b1);
      GRN = 1'b0; YLW = 1'b1;
      tick(); chk("carreq_drop", CAR, 1'b0);
      tick(2);

      // Min green with car_db already 1.
      YLW = 1'b0; GRN = 1'b1;
      tick(); chk("mingreen_e1", CAR, 1'b0);
      tick(); chk("mingreen_e2", CAR, 1'b1);

      // Short RED pulse then a full phase: count restarts.
      GRN = 1'b0; RED = 1'b1;
      tick(); chk("pulse_e1", TIMEOUT, 1'b0);
      tick(); chk("pulse_e2", TIMEOUT, 1'b0);
      RED = 1'b0; YLW = 1'b1;
      tick(); chk("pulse_gap", TIMEOUT, 1'b0);
      YLW = 1'b0; RED = 1'b1;
      tick(); chk("restart_e1", TIMEOUT, 1'b0);
      tick(); chk("restart_e2", TIMEOUT, 1'b0);
      tick(); chk("restart_e3", TIMEOUT, 1'b0);
      tick(); chk("restart_e4", TIMEOUT, 1'b1);

      // Reset mid-phase: clears immediately, counting restarts from 0.
      tick();
      res = 1'b1;
      #1; chk("midreset_async", TIMEOUT, 1'b0);
      tick();
      res = 1'b0;
      tick(); chk("midreset_e1", TIMEOUT, 1'b0);
      tick(); chk("midreset_e2", TIMEOUT, 1'b0);
      tick(); chk("midreset_e3", TIMEOUT, 1'b0);
      tick(); chk("midreset_e4", TIMEOUT, 1'b1);

      // Illegal lamp combination for one edge.
      RED = 1'b0; GRN = 1'b1;
      tick(6);
      chk("pre_fault_CAR", CAR, 1'b1);
      RED = 1'b1;
      tick(); chk("fault_set", lamp_fault, FAULT_ON);
      RED = 1'b0;
      tick(3);
      chk("fault_sticky_g", lamp_fault, FAULT_ON);
      chk("fault_force_CAR", CAR, !FAULT_ON);
      GRN = 1'b0; RED = 1'b1;
      tick(5);
      chk("fault_sticky_r", lamp_fault, FAULT_ON);
      chk("fault_force_TO", TIMEOUT, !FAULT_ON);
      res = 1'b1;
      tick();
      chk("fault_cleared", lamp_fault, 1'b0);
      res = 1'b0;
      tick(4);
      chk("post_fault_TO", TIMEOUT, 1'b1);
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
